seg7_scan_driver: RTL and testbench

Multi-digit, time-multiplexed 7-segment display driver. It is the parametrised successor to the single-digit BCD-to-segment decoder. It latches an N-digit BCD word on a load strobe and scans the digits one at a time with a programmable refresh period. It adds inter-digit ghosting guard, leading-zero blanking, per-digit decimal points and selectable output polarity. It sits between the datapath (counters, clocks, calculators) and the board display pins.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_digit_decode.sv | 38 +++
 rtl/seg7_scan_driver.sv | 105 ++++++++++
 tb/tb_seg7_scan_driver.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment constants and types for the multiplexed 7-segment driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high before output polarity.
package seg7_pkg;

   typedef logic [6:0] seg7_t;

   localparam int BCD_W = 4;

   localparam seg7_t SEG_0     = 7'h3F;
   localparam seg7_t SEG_1     = 7'h06;
   localparam seg7_t SEG_2     = 7'h5B;
   localparam seg7_t SEG_3     = 7'h4F;
   localparam seg7_t SEG_4     = 7'h66;
   localparam seg7_t SEG_5     = 7'h6D;
   localparam seg7_t SEG_6     = 7'h7D;
   localparam seg7_t SEG_7     = 7'h07;
   localparam seg7_t SEG_8     = 7'h7F;
   localparam seg7_t SEG_9     = 7'h6F;
   localparam seg7_t SEG_A     = 7'h77;
   localparam seg7_t SEG_B     = 7'h7C;
   localparam seg7_t SEG_C     = 7'h39;
   localparam seg7_t SEG_D     = 7'h5E;
   localparam seg7_t SEG_E     = 7'h79;
   localparam seg7_t SEG_F     = 7'h71;
   localparam seg7_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational nibble-to-segment decoder with a forced-blank input.
// Define SEG_HEX_EN to render nibbles 10..15 as A b C d E F instead of blank.
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [BCD_W-1:0] i_nibble,
   input  logic             i_blank,
   output seg7_t            o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      if (!i_blank) begin
         case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
`ifdef SEG_HEX_EN
            4'd10:   o_seg = SEG_A;
            4'd11:   o_seg = SEG_B;
            4'd12:   o_seg = SEG_C;
            4'd13:   o_seg = SEG_D;
            4'd14:   o_seg = SEG_E;
            4'd15:   o_seg = SEG_F;
`endif
            default: o_seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: shadow register, scan counters,
// anode guard, leading-zero blanking and output polarity. Hex digits via SEG_HEX_EN.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 2,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [BCD_W*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]       dp_in,
   input  logic                      lzb,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [N_DIGITS-1:0]       an,
   output logic                      frame
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   logic [BCD_W*N_DIGITS-1:0] r_value;
   logic [N_DIGITS-1:0]       r_dp;
   logic                      r_lzb;
   logic [CNT_W-1:0]          r_cnt;
   logic [IDX_W-1:0]          r_idx;
   seg7_t                     r_seg;
   logic                      r_dp_out;
   logic [N_DIGITS-1:0]       r_an;
   logic                      r_frame;

   logic [BCD_W-1:0]          w_nibble [N_DIGITS];
   logic [N_DIGITS-1:0]       w_zero_from;
   logic [N_DIGITS-1:0]       w_blank_vec;
   logic [N_DIGITS-1:0]       w_an_sel;
   logic                      w_last_cnt;
   logic                      w_last_idx;
   logic                      w_guard;
   seg7_t                     w_seg_code;

   // w_zero_from[i]: nibble i and every more-significant nibble are zero
   for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign w_nibble[gi] = r_value[gi*BCD_W +: BCD_W];
      if (gi == N_DIGITS - 1) begin : g_top
         assign w_zero_from[gi] = (w_nibble[gi] == '0);
      end else begin : g_lower
         assign w_zero_from[gi] = (w_nibble[gi] == '0) && w_zero_from[gi+1];
      end
   end

   assign w_blank_vec = r_lzb ? (w_zero_from & ~N_DIGITS'(1)) : '0;
   assign w_last_cnt  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
   assign w_last_idx  = (r_idx == IDX_W'(N_DIGITS - 1));
   assign w_guard     = (r_cnt < CNT_W'(GUARD_CYCLES));
   assign w_an_sel    = N_DIGITS'(1) << r_idx;

   seg7_digit_decode u_decode (
      .i_nibble (w_nibble[r_idx]),
      .i_blank  (w_blank_vec[r_idx]),
      .o_seg    (w_seg_code)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_value  <= '0;
         r_dp     <= '0;
         r_lzb    <= 1'b0;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_frame  <= 1'b0;
         r_seg    <= {7{ACTIVE_LOW}};
         r_dp_out <= ACTIVE_LOW;
         r_an     <= {N_DIGITS{ACTIVE_LOW}};
      end else begin
         if (load) begin
            r_value <= value;
            r_dp    <= dp_in;
            r_lzb   <= lzb;
         end

         if (w_last_cnt) begin
            r_cnt <= '0;
            r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         // Outputs reflect the counters and shadow as they stood before this edge
         r_frame  <= w_last_cnt && w_last_idx;
         r_seg    <= w_seg_code ^ {7{ACTIVE_LOW}};
         r_dp_out <= r_dp[r_idx] ^ ACTIVE_LOW;
         r_an     <= (w_guard ? '0 : w_an_sel) ^ {N_DIGITS{ACTIVE_LOW}};
      end
   end

   assign seg   = r_seg;
   assign dp    = r_dp_out;
   assign an    = r_an;
   assign frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: table vectors, hand-written scan
// sequences and randomized traffic against a cycle-level reference model.
module tb_seg7_scan_driver;

   localparam int N = 4;
   localparam int R = 4;
   localparam int G = 1;

`ifdef SEG_HEX_EN
   localparam logic [6:0] HEX_A = 7'h77;
   localparam logic [6:0] HEX_F = 7'h71;
`else
   localparam logic [6:0] HEX_A = 7'h00;
   localparam logic [6:0] HEX_F = 7'h00;
`endif

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        load  = 1'b0;
   logic        lzb   = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;

   logic [6:0]  seg, seg_al;
   logic        dp, dp_al;
   logic [3:0]  an, an_al;
   logic        frame, frame_al;

   int n_cmp = 0;
   int n_bad = 0;

   seg7_scan_driver #(
      .N_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G), .ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .lzb(lzb),
      .seg(seg), .dp(dp), .an(an), .frame(frame)
   );

   seg7_scan_driver #(
      .N_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G), .ACTIVE_LOW(1'b1)
   ) dut_al (
      .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .lzb(lzb),
      .seg(seg_al), .dp(dp_al), .an(an_al), .frame(frame_al)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [6:0] code_of(int nib);
      case (nib)
         0: return 7'h3F;
         1: return 7'h06;
         2: return 7'h5B;
         3: return 7'h4F;
         4: return 7'h66;
         5: return 7'h6D;
         6: return 7'h7D;
         7: return 7'h07;
         8: return 7'h7F;
         9: return 7'h6F;
`ifdef SEG_HEX_EN
         10: return 7'h77;
         11: return 7'h7C;
         12: return 7'h39;
         13: return 7'h5E;
         14: return 7'h79;
         15: return 7'h71;
`endif
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] digit_seg(logic [15:0] v, logic lz, int d);
      logic [15:0] upper;
      upper = v >> (4 * d);
      if (lz && d > 0 && upper == 16'h0) return 7'h00;
      return code_of(int'(upper[3:0]));
   endfunction

   int          m_phase = 0;
   logic [15:0] m_val;
   logic [3:0]  m_dp;
   logic        m_lzb;
   logic [6:0]  exp_seg;
   logic        exp_dp;
   logic [3:0]  exp_an;
   logic        exp_frame;

   // m_phase counts clean cycles since reset; slot and digit follow by division
   always @(posedge clk) begin
      int c, d;
      if (rst) begin
         m_phase   <= 0;
         m_val     <= '0;
         m_dp      <= '0;
         m_lzb     <= 1'b0;
         exp_seg   <= 7'h00;
         exp_dp    <= 1'b0;
         exp_an    <= 4'h0;
         exp_frame <= 1'b0;
      end else begin
         c = m_phase % R;
         d = (m_phase / R) % N;
         exp_seg   <= digit_seg(m_val, m_lzb, d);
         exp_dp    <= m_dp[d];
         exp_an    <= (c < G) ? 4'h0 : 4'(1 << d);
         exp_frame <= (c == R - 1) && (d == N - 1);
         m_phase   <= m_phase + 1;
         if (load) begin
            m_val <= value;
            m_dp  <= dp_in;
            m_lzb <= lzb;
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic cmp(string name, logic [31:0] got, logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cmp("model_hi", {25'h0, seg, dp, an, frame}, {25'h0, exp_seg, exp_dp, exp_an, exp_frame});
      cmp("model_lo", {25'h0, seg_al, dp_al, an_al, frame_al},
          {25'h0, ~exp_seg, ~exp_dp, ~exp_an, exp_frame});
   endtask

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp_in;
      logic        lzb;
      int          digit;
      logic [6:0]  seg;
      logic        dp;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] scan_seg [4];
      int         frames;
      bit         found;

      vecs.push_back('{16'h1234, 4'b0100, 1'b0, 0, 7'h66, 1'b0});
      vecs.push_back('{16'h1234, 4'b0100, 1'b0, 1, 7'h4F, 1'b0});
      vecs.push_back('{16'h1234, 4'b0100, 1'b0, 2, 7'h5B, 1'b1});
      vecs.push_back('{16'h1234, 4'b0100, 1'b0, 3, 7'h06, 1'b0});
      vecs.push_back('{16'h0070, 4'b0000, 1'b1, 3, 7'h00, 1'b0});
      vecs.push_back('{16'h0070, 4'b0000, 1'b1, 2, 7'h00, 1'b0});
      vecs.push_back('{16'h0070, 4'b0000, 1'b1, 1, 7'h07, 1'b0});
      vecs.push_back('{16'h0070, 4'b0000, 1'b1, 0, 7'h3F, 1'b0});
      vecs.push_back('{16'h0070, 4'b0000, 1'b0, 3, 7'h3F, 1'b0});
      vecs.push_back('{16'h0070, 4'b0000, 1'b0, 2, 7'h3F, 1'b0});
      vecs.push_back('{16'h00AF, 4'b0000, 1'b0, 0, HEX_F, 1'b0});
      vecs.push_back('{16'h00AF, 4'b0000, 1'b0, 1, HEX_A, 1'b0});
      vecs.push_back('{16'h0000, 4'b1000, 1'b1, 3, 7'h00, 1'b1});
      vecs.push_back('{16'h0000, 4'b1000, 1'b1, 0, 7'h3F, 1'b0});
      vecs.push_back('{16'h9999, 4'b0001, 1'b1, 0, 7'h6F, 1'b1});
      vecs.push_back('{16'h0500, 4'b0000, 1'b1, 1, 7'h3F, 1'b0});

      // Reset values for both polarities
      rst = 1'b1;
      repeat (3) step();
      cmp("rst_seg", {25'h0, seg}, 32'h00);
      cmp("rst_dp", {31'h0, dp}, 32'h0);
      cmp("rst_an", {28'h0, an}, 32'h0);
      cmp("rst_frame", {31'h0, frame}, 32'h0);
      cmp("rst_al_seg", {25'h0, seg_al}, 32'h7F);
      cmp("rst_al_dp", {31'h0, dp_al}, 32'h1);
      cmp("rst_al_an", {28'h0, an_al}, 32'hF);

      // Full scan of 1234 with dp on digit 2, two frames
      scan_seg[0] = 7'h66; scan_seg[1] = 7'h4F; scan_seg[2] = 7'h5B; scan_seg[3] = 7'h06;
      value = 16'h1234; dp_in = 4'b0100; lzb = 1'b0; load = 1'b1; rst = 1'b0;
      step();
      load = 1'b0;
      cmp("scan_first_guard", {28'h0, an}, 32'h0);
      frames = 0;
      for (int k = 1; k < 32; k++) begin
         step();
         cmp("scan_an", {28'h0, an}, (k % 4 == 0) ? 32'h0 : 32'(1 << ((k / 4) % 4)));
         cmp("scan_seg", {25'h0, seg}, {25'h0, scan_seg[(k / 4) % 4]});
         cmp("scan_dp", {31'h0, dp}, {31'h0, ((k / 4) % 4) == 2});
         cmp("scan_frame", {31'h0, frame}, {31'h0, (k % 16) == 15});
         if (frame) frames++;
      end
      cmp("frame_count", frames, 2);

      // Table vectors: reset, load, wait for the digit, check the code
      foreach (vecs[i]) begin
         rst = 1'b1;
         step();
         rst = 1'b0;
         value = vecs[i].value; dp_in = vecs[i].dp_in; lzb = vecs[i].lzb; load = 1'b1;
         step();
         load = 1'b0;
         found = 1'b0;
         for (int k = 0; k < 3 * N * R; k++) begin
            if (an == 4'(1 << vecs[i].digit)) begin
               found = 1'b1;
               break;
            end
            step();
         end
         cmp("vec_wait_an", {31'h0, found}, 32'h1);
         cmp("vec_seg", {25'h0, seg}, {25'h0, vecs[i].seg});
         cmp("vec_dp", {31'h0, dp}, {31'h0, vecs[i].dp});
         $display("vec %0d: value=%h lzb=%0d digit=%0d seg=%h dp=%0d", i,
                  vecs[i].value, vecs[i].lzb, vecs[i].digit, seg, dp);
      end

      // Reset while idx=2, cnt=2
      rst = 1'b1;
      step();
      rst = 1'b0; value = 16'h1234; dp_in = 4'b0000; lzb = 1'b0; load = 1'b1;
      step();
      load = 1'b0;
      repeat (9) step();
      cmp("mid_pre_an", {28'h0, an}, 32'h4);
      rst = 1'b1;
      step();
      cmp("mid_rst_an", {28'h0, an}, 32'h0);
      cmp("mid_rst_seg", {25'h0, seg}, 32'h00);
      rst = 1'b0;
      step();
      cmp("mid_guard_an", {28'h0, an}, 32'h0);
      step();
      cmp("mid_restart_an", {28'h0, an}, 32'h1);
      cmp("mid_restart_seg", {25'h0, seg}, 32'h3F);

      // Load 9999 in the middle of digit 1's slot
      rst = 1'b1;
      step();
      rst = 1'b0; value = 16'h1234; load = 1'b1;
      step();
      load = 1'b0;
      repeat (5) step();
      value = 16'h9999; load = 1'b1;
      step();
      load = 1'b0;
      cmp("midload_old_seg", {25'h0, seg}, 32'h4F);
      step();
      cmp("midload_new_seg", {25'h0, seg}, 32'h6F);
      cmp("midload_an", {28'h0, an}, 32'h2);

      // Randomized traffic against the model
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 400; k++) begin
         logic [15:0] v;
         for (int j = 0; j < 4; j++) v[j*4 +: 4] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
         value = v;
         dp_in = 4'($urandom);
         lzb   = 1'($urandom);
         load  = ($urandom % 6 == 0);
         rst   = ($urandom % 80 == 0);
         step();
      end
      rst = 1'b0; load = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
